carry_select_carry_seq: RTL and testbench

Block-serial carry stage for the carry-select adder: accepts a full-width operand pair, then emits one `BLOCK_LEN`-bit slice per beat. Each beat carries the slice's operands and the per-bit carry-in vector `c`, so `carry_select_sum_base` can form `sum = a ^ b ^ c` directly from the beat. The block-to-block carry is kept in a register and chosen with carry-select precomputation (cin=0 and cin=1). This lets wide additions run at block-level critical path.

---
 rtl/carry_select_carry_seq_pkg.sv | 12 +
 rtl/carry_select_carry_base.sv | 40 ++++
 rtl/carry_select_carry_seq.sv | 106 ++++++++++
 tb/tb_carry_select_carry_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_select_carry_seq_pkg.sv
// Shared constants and FSM encoding for the block-serial carry-select carry stage.
package carry_select_carry_seq_pkg;

    localparam int CSC_BLOCK_LEN  = 4;
    localparam int CSC_NUM_BLOCKS = 4;

    typedef enum logic {
        CSC_IDLE = 1'b0,
        CSC_RUN  = 1'b1
    } csc_state_t;

endpackage

// File: rtl/carry_select_carry_base.sv
// Combinational slice carry logic: per-bit carry vector for the actual carry-in,
// plus block carry-out precomputed for carry-in 0 and carry-in 1.
module carry_select_carry_base
    import carry_select_carry_seq_pkg::*;
#(
    parameter int BLOCK_LEN = CSC_BLOCK_LEN
) (
    input  logic [BLOCK_LEN-1:0] a,
    input  logic [BLOCK_LEN-1:0] b,
    input  logic                 cin,
    output logic [BLOCK_LEN-1:0] out_c,
    output logic                 cout0,
    output logic                 cout1
);

    logic [BLOCK_LEN-1:0] g;
    logic [BLOCK_LEN-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        out_c    = '0;
        out_c[0] = cin;
        for (int i = 1; i < BLOCK_LEN; i++) begin
            out_c[i] = g[i-1] | (p[i-1] & out_c[i-1]);
        end
    end

    // Two independent ripples so the block-to-block carry only costs a 2:1 select.
    always_comb begin
        cout0 = 1'b0;
        cout1 = 1'b1;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            cout0 = g[i] | (p[i] & cout0);
            cout1 = g[i] | (p[i] & cout1);
        end
    end

endmodule

// File: rtl/carry_select_carry_seq.sv
// Block-serial carry stage: latches a full-width operand pair, then emits one
// slice per beat with its per-bit carry vector; final carry lands on out_cout.
module carry_select_carry_seq
    import carry_select_carry_seq_pkg::*;
#(
    parameter int  BLOCK_LEN  = CSC_BLOCK_LEN,
    parameter int  NUM_BLOCKS = CSC_NUM_BLOCKS,
    localparam int WIDTH      = BLOCK_LEN * NUM_BLOCKS,
    localparam int IDX_W      = $clog2(NUM_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_LEN-1:0] out_a,
    output logic [BLOCK_LEN-1:0] out_b,
    output logic [BLOCK_LEN-1:0] out_c,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 out_cout,
    output csc_state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a stalled beat holds every out_* bit.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    csc_state_t       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic             cout_reg;

    logic cout0;
    logic cout1;
    logic blk_cout;

    // Operands shift down one slice per beat, so the current slice is always the low bits.
    carry_select_carry_base #(
        .BLOCK_LEN(BLOCK_LEN)
    ) u_base (
        .a    (op_a[BLOCK_LEN-1:0]),
        .b    (op_b[BLOCK_LEN-1:0]),
        .cin  (carry_reg),
        .out_c(out_c),
        .cout0(cout0),
        .cout1(cout1)
    );

    assign blk_cout = carry_reg ? cout1 : cout0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CSC_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                CSC_IDLE: begin
                    if (in_valid) begin
                        op_a      <= in_a;
                        op_b      <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                        state     <= CSC_RUN;
                    end
                end
                CSC_RUN: begin
                    if (out_ready) begin
                        carry_reg <= blk_cout;
                        op_a      <= op_a >> BLOCK_LEN;
                        op_b      <= op_b >> BLOCK_LEN;
                        if (idx == LAST_IDX) begin
                            cout_reg <= blk_cout;
                            idx      <= '0;
                            state    <= CSC_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= CSC_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == CSC_IDLE);
    assign out_valid = (state == CSC_RUN);
    assign out_a     = op_a[BLOCK_LEN-1:0];
    assign out_b     = op_b[BLOCK_LEN-1:0];
    assign out_idx   = idx;
    assign out_last  = (state == CSC_RUN) && (idx == LAST_IDX);
    assign out_cout  = cout_reg;
    assign dbg_state = state;

endmodule

// File: tb/tb_carry_select_carry_seq.sv
// Self-checking bench for carry_select_carry_seq: table vectors, stall/reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_carry_select_carry_seq;
    import carry_select_carry_seq_pkg::*;

    localparam int BL = 4;
    localparam int NB = 4;
    localparam int W  = BL * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [BL-1:0] out_a;
    logic [BL-1:0] out_b;
    logic [BL-1:0] out_c;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          out_cout;
    csc_state_t    dbg_state;

    always #5 clk = ~clk;

    carry_select_carry_seq #(
        .BLOCK_LEN (BL),
        .NUM_BLOCKS(NB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_cout (out_cout),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic [W-1:0] c;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] cur_a, cur_b, cur_c, acc_sum, got_c, done_sum;
    logic         done_cout;
    int           beat_k = 0;
    bit           pending = 0;
    bit           accepted_flag = 0;
    bit           op_done = 0;
    bit           check_spacing = 0;
    int           done_count = 0;
    int           done_cyc = 0;
    int           last_acc = -100;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a falling edge: judges what the coming rising edge will transfer, then advances.
    task automatic step(input logic rdy);
        logic [W:0] e;
        out_ready = rdy;
        cyc++;
        if (pending) begin
            pending = 0;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("op_cout", 32'(out_cout), 32'(e[W]));
                check("op_sum", 32'(acc_sum), 32'(e[W-1:0]));
            end
            done_sum  = acc_sum;
            done_cout = out_cout;
            done_cyc  = cyc;
            op_done   = 1;
            done_count++;
        end
        if (out_valid) check("in_ready_in_run", 32'(in_ready), 32'd0);
        if (in_valid && in_ready) begin
            e = model(in_a, in_b, in_cin);
            exp_q.push_back(e);
            if (check_spacing) check("accept_spacing", 32'((cyc - last_acc) >= NB + 1), 32'd1);
            last_acc      = cyc;
            cur_a         = in_a;
            cur_b         = in_b;
            cur_c         = in_a ^ in_b ^ e[W-1:0];
            acc_sum       = '0;
            got_c         = '0;
            beat_k        = 0;
            accepted_flag = 1;
        end
        if (out_valid && rdy) begin
            if (beat_k >= NB) begin
                check("extra_beat", 32'd1, 32'd0);
            end else begin
                check("beat_idx", 32'(out_idx), 32'(beat_k));
                check("beat_a", 32'(out_a), 32'(cur_a[BL*beat_k +: BL]));
                check("beat_b", 32'(out_b), 32'(cur_b[BL*beat_k +: BL]));
                check("beat_c", 32'(out_c), 32'(cur_c[BL*beat_k +: BL]));
                check("beat_last", 32'(out_last), 32'(beat_k == NB - 1));
                acc_sum[BL*beat_k +: BL] = out_a ^ out_b ^ out_c;
                got_c[BL*beat_k +: BL]   = out_c;
                if (beat_k == NB - 1) pending = 1;
                beat_k++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        accepted_flag = 0;
        for (int i = 0; i < 20 && !accepted_flag; i++) step(1'b1);
        in_valid = 1'b0;
        if (!accepted_flag) check("accept_timeout", 32'd0, 32'd1);
        op_done = 0;
        for (int i = 0; i < 40 && !op_done; i++) step(1'b1);
        if (!op_done) check("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BL-1:0] sa, sb, sc;
        logic [1:0]    si;

        vecs[0] = '{a: 16'h0001, b: 16'h0000, cin: 1'b0, sum: 16'h0001, cout: 1'b0, c: 16'h0000};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, c: 16'hFFFE};
        vecs[2] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, cout: 1'b0, c: 16'h0001};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b1, sum: 16'h0001, cout: 1'b1, c: 16'h0001};
        vecs[4] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0, c: 16'h0440};
        vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, c: 16'hFFFF};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(CSC_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].cin);
            check("tbl_sum", 32'(done_sum), 32'(vecs[v].sum));
            check("tbl_cout", 32'(done_cout), 32'(vecs[v].cout));
            check("tbl_c", 32'(got_c), 32'(vecs[v].c));
            check("tbl_idle_after", 32'(in_ready), 32'd1);
        end

        // Backpressure on slice 1 for three cycles.
        in_a = 16'hF0F0;
        in_b = 16'h1F10;
        in_cin = 1'b0;
        in_valid = 1'b1;
        accepted_flag = 0;
        for (int i = 0; i < 20 && !accepted_flag; i++) step(1'b1);
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted_flag), 32'd1);
        for (int i = 0; i < 20 && beat_k != 1; i++) step(1'b1);
        check("bp_at_idx1", 32'(out_idx), 32'd1);
        sa = out_a;
        sb = out_b;
        sc = out_c;
        si = out_idx;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("bp_hold_a", 32'(out_a), 32'(sa));
            check("bp_hold_b", 32'(out_b), 32'(sb));
            check("bp_hold_c", 32'(out_c), 32'(sc));
            check("bp_hold_idx", 32'(out_idx), 32'(si));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        op_done = 0;
        for (int i = 0; i < 40 && !op_done; i++) step(1'b1);
        check("bp_done", 32'(op_done), 32'd1);
        check("bp_latency", 32'(done_cyc - last_acc), 32'(NB + 1 + 3));
        check("bp_sum", 32'(done_sum), 32'h1000);
        check("bp_cout", 32'(done_cout), 32'd1);

        // Asynchronous reset while slice 2 is on the output.
        in_a = 16'h0F0F;
        in_b = 16'h00F1;
        in_cin = 1'b1;
        in_valid = 1'b1;
        accepted_flag = 0;
        for (int i = 0; i < 20 && !accepted_flag; i++) step(1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && beat_k != 2; i++) step(1'b1);
        check("mr_valid_before", 32'(out_valid), 32'd1);
        check("mr_idx_before", 32'(out_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_cout", 32'(out_cout), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_out_idx", 32'(out_idx), 32'd0);
        check("mr_state", 32'(dbg_state), 32'(CSC_IDLE));
        exp_q.delete();
        pending = 0;
        beat_k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_in_ready_after", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h4321, 1'b0);
        check("mr_fresh_sum", 32'(done_sum), 32'h5555);
        check("mr_fresh_cout", 32'(done_cout), 32'd0);

        // Random traffic with in_valid held high and operands changing every cycle.
        check_spacing = 1;
        done_count = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20000 && done_count < 1000; i++) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_cin = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        check("random_ops_done", 32'(done_count >= 1000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
